// File: rtl/pci_arbiter.sv
// Four-master PCI bus arbiter: round-robin grants, start timeout,
// early grant release during a transaction when others are waiting.
module pci_arbiter #(
  parameter int N_MASTERS     = 4,
  parameter int START_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_MASTERS-1:0] REQ_n,
  input  logic                 Frame,
  input  logic                 IRDY,
  output logic [N_MASTERS-1:0] GNT_n,
  output logic [1:0]           OWNER,
  output logic                 OWNER_VALID,
  output logic                 TIMEOUT_ERR,
  output logic [1:0]           ARB_STATE
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    TURN  = 2'd3
  } state_t;

  localparam logic [3:0] TO_LAST = 4'(START_TIMEOUT - 1);

  state_t     state, state_d;
  logic [3:0] gnt_d;
  logic [1:0] owner_d;
  logic [1:0] last, last_d;
  logic [3:0] cnt, cnt_d;
  logic       err_d;

  logic [3:0] req;
  logic [3:0] others;
  logic       bus_idle;
  logic [1:0] win;
  logic [1:0] idx;
  logic       found;

  assign req      = ~REQ_n;
  assign bus_idle = Frame & IRDY;
  assign others   = req & ~(4'b0001 << OWNER);

  // Search starts just past the most recent grantee.
  always_comb begin
    win   = 2'd0;
    idx   = 2'd0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state;
    gnt_d   = GNT_n;
    owner_d = OWNER;
    last_d  = last;
    cnt_d   = cnt;
    err_d   = 1'b0;
    unique case (state)
      IDLE: begin
        gnt_d = 4'hF;
        if (found) begin
          state_d = GRANT;
          gnt_d   = ~(4'b0001 << win);
          owner_d = win;
          last_d  = win;
          cnt_d   = 4'd0;
        end
      end
      GRANT: begin
        if (!Frame) begin
          state_d = BUSY;
        end else if (!req[OWNER]) begin
          state_d = TURN;
          gnt_d   = 4'hF;
        end else if (cnt == TO_LAST) begin
          state_d = TURN;
          gnt_d   = 4'hF;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt + 4'd1;
        end
      end
      BUSY: begin
        if (bus_idle) begin
          state_d = TURN;
          gnt_d   = 4'hF;
        end else if (|others) begin
          gnt_d = 4'hF;
        end
      end
      TURN: begin
        state_d = IDLE;
        gnt_d   = 4'hF;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'hF;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      GNT_n       <= 4'hF;
      OWNER       <= 2'd0;
      last        <= 2'd3;
      cnt         <= 4'd0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      state       <= state_d;
      GNT_n       <= gnt_d;
      OWNER       <= owner_d;
      last        <= last_d;
      cnt         <= cnt_d;
      TIMEOUT_ERR <= err_d;
    end
  end

  assign OWNER_VALID = (state == GRANT) || (state == BUSY);
  assign ARB_STATE   = state;

endmodule

// File: tb/tb_pci_arbiter.sv
// Bench for pci_arbiter: directed scenarios plus random traffic
// compared each cycle against a behavioural arbiter model.
module tb_pci_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] REQ_n;
  logic       Frame;
  logic       IRDY;
  logic [3:0] GNT_n;
  logic [1:0] OWNER;
  logic       OWNER_VALID;
  logic       TIMEOUT_ERR;
  logic [1:0] ARB_STATE;

  int vectors = 0;
  int miscompares = 0;

  pci_arbiter #(.N_MASTERS(4), .START_TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .REQ_n       (REQ_n),
    .Frame       (Frame),
    .IRDY        (IRDY),
    .GNT_n       (GNT_n),
    .OWNER       (OWNER),
    .OWNER_VALID (OWNER_VALID),
    .TIMEOUT_ERR (TIMEOUT_ERR),
    .ARB_STATE   (ARB_STATE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h",
               tag, $time, got, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 granted, 2 transaction, 3 turnaround
  int       m_phase = 0;
  int       m_owner = 0;
  int       m_last  = 3;
  int       m_wait  = 0;
  bit [3:0] m_gnt   = 4'hF;
  bit       m_err   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_owner = 0;
      m_last  = 3;
      m_wait  = 0;
      m_gnt   = 4'hF;
      m_err   = 1'b0;
    end else begin
      bit found;
      bit other;
      m_err = 1'b0;
      case (m_phase)
        0: begin
          found = 1'b0;
          for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_last + k) % 4;
            if (!found && REQ_n[c] == 1'b0) begin
              found   = 1'b1;
              m_owner = c;
            end
          end
          if (found) begin
            m_last  = m_owner;
            m_phase = 1;
            m_wait  = 1;
            m_gnt   = 4'hF;
            m_gnt[m_owner] = 1'b0;
          end
        end
        1: begin
          if (Frame == 1'b0) begin
            m_phase = 2;
          end else if (REQ_n[m_owner] == 1'b1) begin
            m_phase = 3;
            m_gnt   = 4'hF;
          end else if (m_wait >= 16) begin
            m_phase = 3;
            m_gnt   = 4'hF;
            m_err   = 1'b1;
          end else begin
            m_wait++;
          end
        end
        2: begin
          other = 1'b0;
          for (int i = 0; i < 4; i++)
            if (i != m_owner && REQ_n[i] == 1'b0) other = 1'b1;
          if (Frame && IRDY) begin
            m_phase = 3;
            m_gnt   = 4'hF;
          end else if (other) begin
            m_gnt = 4'hF;
          end
        end
        default: begin
          m_phase = 0;
          m_gnt   = 4'hF;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("gnt", 32'(GNT_n), 32'(m_gnt));
    chk("owner", 32'(OWNER), 32'(m_owner));
    chk("valid", 32'(OWNER_VALID), 32'(m_phase == 1 || m_phase == 2));
    chk("terr", 32'(TIMEOUT_ERR), 32'(m_err));
    chk("state", 32'(ARB_STATE), 32'(m_phase));
    chk("onehot", 32'($countones(~GNT_n) <= 1), 32'd1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int low_clks;
    rst_n = 1'b0;
    REQ_n = 4'hF;
    Frame = 1'b1;
    IRDY  = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;

    // masters 0 and 3 request after reset: 0 wins
    REQ_n = 4'b0110;
    tick();
    chk("d030_gnt", 32'(GNT_n), 32'hE);
    chk("d030_own", 32'(OWNER), 32'd0);
    chk("d030_st", 32'(ARB_STATE), 32'd1);

    // transaction by 0, master 2 waiting forces early release
    tick();
    Frame = 1'b0;
    REQ_n = 4'b1010;
    tick();
    chk("d031_busy", 32'(ARB_STATE), 32'd2);
    chk("d031_hold", 32'(GNT_n), 32'hE);
    tick();
    chk("d031_rel", 32'(GNT_n), 32'hF);
    chk("d031_st", 32'(ARB_STATE), 32'd2);
    Frame = 1'b1;
    IRDY  = 1'b1;
    tick();
    chk("d031_turn", 32'(ARB_STATE), 32'd3);
    tick();
    chk("d031_idle", 32'(ARB_STATE), 32'd0);
    tick();
    chk("d031_gnt", 32'(GNT_n), 32'hB);
    chk("d031_own", 32'(OWNER), 32'd2);
    REQ_n = 4'hF;
    repeat (3) tick();

    // master 1 never starts: grant revoked after 16 clocks
    REQ_n = 4'b1101;
    tick();
    chk("d033_gnt", 32'(GNT_n), 32'hD);
    low_clks = 1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (GNT_n[1] == 1'b0) low_clks++;
      else break;
    end
    chk("d033_len", 32'(low_clks), 32'd16);
    chk("d033_err", 32'(TIMEOUT_ERR), 32'd1);
    chk("d033_turn", 32'(ARB_STATE), 32'd3);
    REQ_n = 4'hF;
    tick();
    chk("d033_idle", 32'(ARB_STATE), 32'd0);
    chk("d033_errclr", 32'(TIMEOUT_ERR), 32'd0);
    tick();

    // master 2 drops request as Frame falls: transaction wins
    REQ_n = 4'b1011;
    tick();
    chk("d034_gnt0", 32'(GNT_n), 32'hB);
    REQ_n = 4'hF;
    Frame = 1'b0;
    tick();
    chk("d034_st", 32'(ARB_STATE), 32'd2);
    chk("d034_gnt", 32'(GNT_n), 32'hB);
    chk("d034_err", 32'(TIMEOUT_ERR), 32'd0);
    Frame = 1'b1;
    repeat (2) tick();

    // async reset in BUSY with master 3 owner
    REQ_n = 4'b0111;
    tick();
    chk("d035_own", 32'(OWNER), 32'd3);
    Frame = 1'b0;
    tick();
    chk("d035_busy", 32'(ARB_STATE), 32'd2);
    #2 rst_n = 1'b0;
    #1 chk("d035_rst", 32'(GNT_n), 32'hF);
    chk("d035_rstst", 32'(ARB_STATE), 32'd0);
    tick();
    rst_n = 1'b1;
    Frame = 1'b1;
    REQ_n = 4'b0111;
    tick();
    chk("d035_regnt", 32'(GNT_n), 32'h7);
    REQ_n = 4'hF;
    repeat (3) tick();

    // random traffic; alternate stretches of idle Frame to hit timeouts
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) REQ_n[b] = ~REQ_n[b];
      if ((i / 200) % 2 == 1) Frame = 1'b1;
      else Frame = ($urandom_range(0, 3) != 0);
      IRDY = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
